vram_arbiter: RTL
=================

# vram_arbiter

Shares the single-port 64K×16 VRAM between the video generator and three requesters: host port A, host port B and the blitter. The video generator owns every cycle in which its `blit_cycle_o` is low. Every other cycle is a free slot, handed round-robin to pending requesters with a req/ack handshake. The block sits between `video_gen`, the register interface, the blitter and the VRAM BRAM.

## Interface
Parameters:
- none; VRAM geometry is fixed at 16-bit address and 16-bit data.

Ports (k ∈ {a, b, blt}):
- `clk`  in  1  pixel/system clock; single clock domain.
- `reset_n_i`  in  1  reset, asynchronous assert, active-low.
- `blit_cycle_i`  in  1  from `video_gen`; 1 = free slot, 0 = video slot.
- `video_sel_i`  in  1  video VRAM select.
- `video_addr_i`  in  16  video VRAM address.
- `k_req_i`  in  1  request; held until ack.
- `k_wr_i`  in  1  1 = write, 0 = read; held with req.
- `k_addr_i`  in  16  word address; held with req.
- `k_data_i`  in  16  write data; held with req.
- `k_ack_o`  out  1  one-cycle pulse: access done; read data valid.
- `rd_data_o`  out  16  read data, common to all requesters.
- `vram_sel_o`  out  1  VRAM select.
- `vram_wr_o`  out  1  VRAM write enable.
- `vram_addr_o`  out  16  VRAM address.
- `vram_data_o`  out  16  VRAM write data.
- `vram_data_i`  in  16  VRAM read data; 1-cycle latency.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Video slot** (`blit_cycle_i`=0):
  - `vram_sel_o`=`video_sel_i`, `vram_addr_o`=`video_addr_i`, `vram_wr_o`=0.
  - The video path is combinational so that `video_gen`'s fixed read timing is preserved.
  - No grant is issued.
- **Free slot** (`blit_cycle_i`=1):
  - Eligible set = {k : `k_req_i`=1 and k not in-flight}. k is in-flight in the cycle where its `k_ack_o` is 1.
  - If the set is non-empty, grant one requester g, combinationally:
    - `vram_sel_o`=1, `vram_wr_o`=`g_wr_i`, `vram_addr_o`=`g_addr_i`, `vram_data_o`=`g_data_i`.
  - If the set is empty: `vram_sel_o`=0, `vram_wr_o`=0.
- **Round-robin:**
  - Registered `last` pointer, order a→b→blt→a.
  - Search starts at the requester after `last`.
  - `last` updates to g on every grant.
  - Reset value of `last` = blt, so a wins first.
- **Acknowledge:**
  - `g_ack_o` is registered and pulses in the cycle after the grant, for both reads and writes.
  - `rd_data_o`=`vram_data_i`, combinational; valid only while some `k_ack_o`=1.
  - The requester may drop or change req/addr in the ack cycle. A new request may be presented in the cycle after ack.
- **Protocol error:** if `video_sel_i`=1 while `blit_cycle_i`=1:
  - video wins (video mux selected);
  - no grant;
  - `err_o` is set and stays 1 until reset.
- **Idle outputs:** `vram_addr_o` and `vram_data_o` are don't-care when `vram_sel_o`=0. Implementation drives the video values.

## Timing
- **Reset** (`reset_n_i`=0, asynchronous):
  - all `k_ack_o`=0, `err_o`=0, `last`=blt;
  - combinational outputs forced `vram_sel_o`=0, `vram_wr_o`=0; no grants.
  - Reset mid-access drops any pending ack; the requester must re-request.
- **Latency:** req seen in free slot N → `vram_sel_o` in N → ack and data in N+1.
- **Minimum repeat for one requester:** every 2 cycles.
- **Aggregate throughput:** one access per free slot.
- **Back-to-back free slots:** N grants x, N+1 grants y≠x. `rd_data_o` in N+1 is x's data; y's data appears in N+2.
- **Free slot followed by video slot:** the ack still fires in the video slot. A video read in that cycle does not conflict, because the BRAM output in N+1 belongs to the N access.
- **Starvation bound:** a requester holding req waits at most 3 free slots.
- **Req during video slot:** no grant; the request waits for the next free slot.

## Test plan
- **Reset defaults:** hold `reset_n_i`=0 with a_req=1 and `blit_cycle_i`=1 → `vram_sel_o`=0, all acks 0. Release → first grant to a.
- **Single read:** a reads addr 0x1234, VRAM holds 0xBEEF there, free slot → `vram_sel_o`=1, `vram_addr_o`=0x1234, `vram_wr_o`=0. Next cycle `a_ack_o`=1 and `rd_data_o`=0xBEEF.
- **Round-robin:** a, b and blt all requesting continuously, `blit_cycle_i`=1 → grants a,b,blt,a,b,blt. Each ack arrives one cycle after its grant, and no requester is granted in its own ack cycle.
- **Video ownership:** `blit_cycle_i` pattern 0,0,1,1 repeating, video reads 0x0100, blt write pending → VRAM follows video addr in the 0-cycles. The blt write (wr=1, data 0x5A5A) lands only in a 1-cycle.
- **Protocol error:** `video_sel_i`=1 with `blit_cycle_i`=1 and b_req=1 → no b grant, `err_o`=1, held until reset.
- **Async reset mid-access:** grant in cycle N, `reset_n_i` dropped before edge N+1 → `b_ack_o` never pulses, `err_o`=0. After release, b is granted again.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, video generator, three requesters and the VRAM BRAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface vram_arbiter_if;
    logic        blit_cycle_i;
    logic        video_sel_i;
    logic [15:0] video_addr_i;

    logic        a_req_i;
    logic        a_wr_i;
    logic [15:0] a_addr_i;
    logic [15:0] a_data_i;
    logic        a_ack_o;

    logic        b_req_i;
    logic        b_wr_i;
    logic [15:0] b_addr_i;
    logic [15:0] b_data_i;
    logic        b_ack_o;

    logic        blt_req_i;
    logic        blt_wr_i;
    logic [15:0] blt_addr_i;
    logic [15:0] blt_data_i;
    logic        blt_ack_o;

    logic [15:0] rd_data_o;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i;
    logic        err_o;

    modport slave (
        input  blit_cycle_i, video_sel_i, video_addr_i,
        input  a_req_i, a_wr_i, a_addr_i, a_data_i,
        input  b_req_i, b_wr_i, b_addr_i, b_data_i,
        input  blt_req_i, blt_wr_i, blt_addr_i, blt_data_i,
        input  vram_data_i,
        output a_ack_o, b_ack_o, blt_ack_o,
        output rd_data_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o, err_o
    );

    modport master (
        output blit_cycle_i, video_sel_i, video_addr_i,
        output a_req_i, a_wr_i, a_addr_i, a_data_i,
        output b_req_i, b_wr_i, b_addr_i, b_data_i,
        output blt_req_i, blt_wr_i, blt_addr_i, blt_data_i,
        output vram_data_i,
        input  a_ack_o, b_ack_o, blt_ack_o,
        input  rd_data_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o, err_o
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between the video generator (owner of every non-blit cycle)
// and three requesters served round-robin in free slots with a one-cycle req/ack handshake.
module vram_arbiter (
    input logic           clk,
    input logic           reset_n_i,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        REQ_A   = 2'd0,
        REQ_B   = 2'd1,
        REQ_BLT = 2'd2
    } req_id_e;

    req_id_e    last_q;
    req_id_e    grant_id;
    logic       grant_valid;
    logic [2:0] grant_vec;
    logic [2:0] req_vec;
    logic [2:0] ack_q;
    logic [2:0] eligible;
    logic       proto_err;
    logic       err_q;

    assign req_vec   = {bus.blt_req_i, bus.b_req_i, bus.a_req_i};
    assign proto_err = bus.blit_cycle_i & bus.video_sel_i;

    // A requester whose ack is showing this cycle is still finishing and may not be re-granted.
    assign eligible = (reset_n_i && bus.blit_cycle_i && !bus.video_sel_i) ?
                      (req_vec & ~ack_q) : 3'b000;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_A;
        case (last_q)
            REQ_A: begin
                if (eligible[1])      begin grant_valid = 1'b1; grant_id = REQ_B;   end
                else if (eligible[2]) begin grant_valid = 1'b1; grant_id = REQ_BLT; end
                else if (eligible[0]) begin grant_valid = 1'b1; grant_id = REQ_A;   end
            end
            REQ_B: begin
                if (eligible[2])      begin grant_valid = 1'b1; grant_id = REQ_BLT; end
                else if (eligible[0]) begin grant_valid = 1'b1; grant_id = REQ_A;   end
                else if (eligible[1]) begin grant_valid = 1'b1; grant_id = REQ_B;   end
            end
            default: begin
                if (eligible[0])      begin grant_valid = 1'b1; grant_id = REQ_A;   end
                else if (eligible[1]) begin grant_valid = 1'b1; grant_id = REQ_B;   end
                else if (eligible[2]) begin grant_valid = 1'b1; grant_id = REQ_BLT; end
            end
        endcase
        grant_vec = grant_valid ? (3'b001 << grant_id) : 3'b000;
    end

    // Video path stays purely combinational; idle address/data fall back to the video values.
    always_comb begin
        bus.vram_sel_o  = 1'b0;
        bus.vram_wr_o   = 1'b0;
        bus.vram_addr_o = bus.video_addr_i;
        bus.vram_data_o = 16'h0000;
        if (!reset_n_i) begin
            bus.vram_sel_o = 1'b0;
        end else if (grant_valid) begin
            bus.vram_sel_o = 1'b1;
            case (grant_id)
                REQ_A: begin
                    bus.vram_wr_o   = bus.a_wr_i;
                    bus.vram_addr_o = bus.a_addr_i;
                    bus.vram_data_o = bus.a_data_i;
                end
                REQ_B: begin
                    bus.vram_wr_o   = bus.b_wr_i;
                    bus.vram_addr_o = bus.b_addr_i;
                    bus.vram_data_o = bus.b_data_i;
                end
                default: begin
                    bus.vram_wr_o   = bus.blt_wr_i;
                    bus.vram_addr_o = bus.blt_addr_i;
                    bus.vram_data_o = bus.blt_data_i;
                end
            endcase
        end else begin
            bus.vram_sel_o = bus.video_sel_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_q <= REQ_BLT;
            ack_q  <= 3'b000;
            err_q  <= 1'b0;
        end else begin
            ack_q <= grant_vec;
            if (grant_valid) begin
                last_q <= grant_id;
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.a_ack_o   = ack_q[0];
    assign bus.b_ack_o   = ack_q[1];
    assign bus.blt_ack_o = ack_q[2];
    assign bus.rd_data_o = bus.vram_data_i;
    assign bus.err_o     = err_q;

endmodule
